bhg_fp_clk_div_ctrl: RTL and testbench

//  Run-time programmable 13.16 fractional clock divider with a start/stop sequencer.

---
 rtl/bhg_fp_clk_div_ctrl.sv | 144 ++++++++++++++
 tb/tb_bhg_fp_clk_div_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bhg_fp_clk_div_ctrl.sv
// Run-time programmable 13.16 fractional clock divider with a start/stop sequencer.
// A phase accumulator toggles clk_out; ratio changes are deferred to the next clk_out rise.
module bhg_fp_clk_div_ctrl #(
  parameter longint unsigned INPUT_CLK_HZ  = 100000000,
  parameter longint unsigned OUTPUT_CLK_HZ = 3579545,
  parameter bit              AUTO_START    = 1'b0
) (
  input  logic        clk_in,
  input  logic        rst_in_n,
  input  logic        start,
  input  logic        stop,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [28:0] cfg_div,
  output logic        cfg_err,
  output logic        clk_out,
  output logic        clk_p0,
  output logic        clk_p180,
  output logic        running,
  output logic [28:0] div_active
);

  localparam logic [63:0] DEF_DIV64 = (64'(INPUT_CLK_HZ) * 64'd65536) / 64'(OUTPUT_CLK_HZ);
  localparam logic [28:0] DEF_DIV   = DEF_DIV64[28:0];
  localparam logic [29:0] STEP      = 30'h0002_0000;

  typedef enum logic [1:0] {IDLE, RUN, PEND, STOPPING} state_t;
  localparam state_t RESET_STATE = AUTO_START ? RUN : IDLE;

  state_t      state_reg, state_next;
  logic [29:0] acc_reg, acc_next;
  logic [28:0] div_active_reg, div_active_next;
  logic [28:0] pend_div_reg, pend_div_next;
  logic        pend_valid_reg, pend_valid_next;
  logic        clk_out_reg, clk_out_next;
  logic        clk_p0_reg, clk_p0_next;
  logic        clk_p180_reg, clk_p180_next;
  logic        cfg_err_reg, cfg_err_next;

  logic        cfg_fire, cfg_legal, cfg_take, tick;
  logic [29:0] acc_sum, half;

  // A held word blocks the port until it has been applied.
  assign cfg_ready = ~pend_valid_reg;
  assign cfg_fire  = cfg_valid & cfg_ready;
  assign cfg_legal = (cfg_div[28:16] >= 13'd2);
  assign cfg_take  = cfg_fire & cfg_legal;
  assign half      = {1'b0, div_active_reg};
  assign acc_sum   = acc_reg + STEP;
  assign tick      = (acc_sum >= half);

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_reg      <= RESET_STATE;
      acc_reg        <= '0;
      div_active_reg <= DEF_DIV;
      pend_div_reg   <= '0;
      pend_valid_reg <= 1'b0;
      clk_out_reg    <= 1'b0;
      clk_p0_reg     <= 1'b0;
      clk_p180_reg   <= 1'b0;
      cfg_err_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      acc_reg        <= acc_next;
      div_active_reg <= div_active_next;
      pend_div_reg   <= pend_div_next;
      pend_valid_reg <= pend_valid_next;
      clk_out_reg    <= clk_out_next;
      clk_p0_reg     <= clk_p0_next;
      clk_p180_reg   <= clk_p180_next;
      cfg_err_reg    <= cfg_err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    acc_next        = acc_reg;
    div_active_next = div_active_reg;
    pend_div_next   = pend_div_reg;
    pend_valid_next = pend_valid_reg;
    clk_out_next    = clk_out_reg;
    clk_p0_next     = 1'b0;
    clk_p180_next   = 1'b0;
    cfg_err_next    = cfg_fire & ~cfg_legal;

    if (state_reg == IDLE) begin
      clk_out_next = 1'b0;
      acc_next     = '0;
      if (cfg_take) div_active_next = cfg_div;
      if (start && !stop) begin
        clk_out_next = 1'b1;
        clk_p0_next  = 1'b1;
        state_next   = RUN;
      end
    end else begin
      // Strobes are registered alongside clk_out so they line up exactly.
      if (tick) begin
        acc_next      = acc_sum - half;
        clk_out_next  = ~clk_out_reg;
        clk_p0_next   = ~clk_out_reg;
        clk_p180_next = clk_out_reg;
      end else begin
        acc_next = acc_sum;
      end
      if (cfg_take) begin
        pend_div_next   = cfg_div;
        pend_valid_next = 1'b1;
      end
      case (state_reg)
        RUN: begin
          if (stop)          state_next = STOPPING;
          else if (cfg_take) state_next = PEND;
        end
        PEND: begin
          if (stop) begin
            state_next = STOPPING;
          end else if (tick && !clk_out_reg) begin
            div_active_next = pend_div_reg;
            pend_valid_next = 1'b0;
            state_next      = RUN;
          end
        end
        STOPPING: begin
          if (tick && clk_out_reg) begin
            state_next      = IDLE;
            pend_valid_next = 1'b0;
            if (pend_valid_reg) div_active_next = pend_div_reg;
            else if (cfg_take)  div_active_next = cfg_div;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign clk_out    = clk_out_reg;
  assign clk_p0     = clk_p0_reg;
  assign clk_p180   = clk_p180_reg;
  assign cfg_err    = cfg_err_reg;
  assign running    = (state_reg != IDLE);
  assign div_active = div_active_reg;

endmodule

// File: tb/tb_bhg_fp_clk_div_ctrl.sv
// Directed bench for bhg_fp_clk_div_ctrl: ratio loading, phase patterns, retune, stop and reset.
module tb_bhg_fp_clk_div_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [28:0] cfg_div = '0;
  logic        cfg_ready, cfg_err, clk_out, clk_p0, clk_p180, running;
  logic [28:0] div_active;

  int checks = 0;
  int failures = 0;

  localparam logic [28:0] DEF_DIV = 29'h01BEFBF;

  bhg_fp_clk_div_ctrl #(
    .INPUT_CLK_HZ(100000000),
    .OUTPUT_CLK_HZ(3579545),
    .AUTO_START(1'b0)
  ) dut (
    .clk_in(clk_in),
    .rst_in_n(rst_in_n),
    .start(start),
    .stop(stop),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_div(cfg_div),
    .cfg_err(cfg_err),
    .clk_out(clk_out),
    .clk_p0(clk_p0),
    .clk_p180(clk_p180),
    .running(running),
    .div_active(div_active)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp1[8];
    int exp4[12];
    int rdy4[12];
    int exp2[10];
    int rises;

    exp1 = '{1, 1, 0, 0, 1, 1, 0, 0};
    exp4 = '{1, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1};
    rdy4 = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    exp2 = '{1, 1, 0, 1, 0, 1, 1, 0, 1, 0};

    // Reset values
    repeat (3) @(negedge clk_in);
    check("rst_clk_out", clk_out, 0);
    check("rst_p0", clk_p0, 0);
    check("rst_p180", clk_p180, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_running", running, 0);
    check("rst_div_active", div_active, DEF_DIV);
    rst_in_n = 1'b1;

    // Test 1: load 4.0 together with start
    @(negedge clk_in);
    $display("txn: cfg 0x0040000 + start in IDLE");
    cfg_valid = 1'b1; cfg_div = 29'h0040000; start = 1'b1;
    @(negedge clk_in);
    cfg_valid = 1'b0; start = 1'b0;
    check("t1_clk_k1", clk_out, 1);
    check("t1_p0_k1", clk_p0, 1);
    check("t1_running", running, 1);
    check("t1_div_active", div_active, 29'h0040000);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk_in);
      check($sformatf("t1_clk_k%0d", i + 1), clk_out, exp1[i]);
    end

    // Test 4: retune to 8.0 mid-high-phase
    @(negedge clk_in);
    check("t4_p0_offer", clk_p0, 1);
    check("t4_ready_offer", cfg_ready, 1);
    $display("txn: cfg 0x0080000 in RUN during high phase");
    cfg_valid = 1'b1; cfg_div = 29'h0080000;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_in);
      cfg_valid = 1'b0;
      check($sformatf("t4_clk_s%0d", i), clk_out, exp4[i]);
      check($sformatf("t4_ready_s%0d", i), cfg_ready, rdy4[i]);
      if (i == 1) check("t4_p180", clk_p180, 1);
      if (i == 3) check("t4_p0_apply", clk_p0, 1);
      if (i == 3) check("t4_div_active", div_active, 29'h0080000);
    end
    check("t4_p0_next", clk_p0, 1);

    // Test 5: illegal word, then stop mid-high-phase
    $display("txn: cfg 0x0018000 (illegal) in RUN");
    cfg_valid = 1'b1; cfg_div = 29'h0018000;
    @(negedge clk_in);
    cfg_valid = 1'b0;
    check("t5_cfg_err", cfg_err, 1);
    check("t5_div_kept", div_active, 29'h0080000);
    $display("txn: stop in RUN during high phase");
    stop = 1'b1;
    @(negedge clk_in);
    stop = 1'b0;
    check("t5_err_pulse", cfg_err, 0);
    check("t5_stopping_run", running, 1);
    check("t5_clk_hi3", clk_out, 1);
    @(negedge clk_in);
    check("t5_clk_hi4", clk_out, 1);
    @(negedge clk_in);
    check("t5_clk_fall", clk_out, 0);
    check("t5_p180", clk_p180, 1);
    check("t5_running_off", running, 0);
    repeat (8) @(negedge clk_in);
    check("t5_clk_idle", clk_out, 0);
    check("t5_p0_idle", clk_p0, 0);

    // Test 6a: start+stop together in IDLE
    $display("txn: start+stop in IDLE");
    start = 1'b1; stop = 1'b1;
    @(negedge clk_in);
    start = 1'b0; stop = 1'b0;
    check("t6a_running", running, 0);
    check("t6a_clk", clk_out, 0);
    check("t6a_p0", clk_p0, 0);

    // Test 2: 2.5 ratio
    $display("txn: cfg 0x0028000 in IDLE");
    cfg_valid = 1'b1; cfg_div = 29'h0028000;
    @(negedge clk_in);
    cfg_valid = 1'b0;
    check("t2_div_active", div_active, 29'h0028000);
    $display("txn: start");
    start = 1'b1;
    rises = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      start = 1'b0;
      if (clk_p0) rises++;
      check($sformatf("t2_clk_k%0d", i + 1), clk_out, exp2[i]);
    end
    check("t2_rises", rises, 4);

    // Test 6b: async reset with a pending word
    $display("txn: cfg 0x0080000 in RUN, then reset");
    cfg_valid = 1'b1; cfg_div = 29'h0080000;
    @(negedge clk_in);
    cfg_valid = 1'b0;
    check("t6b_pend_ready", cfg_ready, 0);
    #2 rst_in_n = 1'b0;
    #1;
    check("t6b_clk", clk_out, 0);
    check("t6b_running", running, 0);
    check("t6b_ready", cfg_ready, 1);
    check("t6b_div", div_active, DEF_DIV);
    check("t6b_p0", clk_p0, 0);
    check("t6b_p180", clk_p180, 0);
    repeat (2) @(negedge clk_in);
    rst_in_n = 1'b1;
    repeat (3) @(negedge clk_in);
    check("t6b_idle", running, 0);
    check("t6b_div_after", div_active, DEF_DIV);

    // Test 3: default ratio over 10000 cycles
    $display("txn: start with default ratio");
    start = 1'b1;
    rises = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk_in);
      start = 1'b0;
      if (clk_p0) rises++;
    end
    check("t3_rises_in_range", (rises == 357 || rises == 358) ? 1 : 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
